// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_load;
  logic             w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Full-subtractor cell on the operand LSBs.
  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt  = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  // Partial result keeps only the top WIDTH-1 bits; the new bit completes the word.
  assign w_res_nxt = {w_d, r_res};
  assign w_load    = (r_state == S_IDLE) && start;
  assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_cnt      <= '0;
      r_br       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_nxt[WIDTH-1:1];
      r_br  <= w_br_nxt;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        diff       <= w_res_nxt;
        borrow_out <= w_br_nxt;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic r_sa;
  logic r_sb;

  // Sign bits are kept aside because the operand registers shift them away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_load) begin
      r_sa <= a[WIDTH-1];
      r_sb <= b[WIDTH-1];
    end else if (w_last) begin
      ovf <= (r_sa != r_sb) && (w_d != r_sa);
    end
  end
`endif

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errs = 0;
  int   n_done = 0;
  int   n_push = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) chk("busy_fall", {31'd0, busy}, 32'd0);
      if (done) begin
        exp_t e;
        n_done++;
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("diff", {24'd0, diff}, {24'd0, e.d});
          chk("borrow_out", {31'd0, borrow_out}, {31'd0, e.br});
`ifdef SUB_OVERFLOW_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
          chk("done_latency", cyc, e.cyc);
          chk("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Start is presented for one edge; when accepted, done is due W cycles later.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input bit accept);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    if (accept) begin
      e.d = ed; e.br = eb; e.ov = eo; e.cyc = cyc + W;
      q.push_back(e);
      n_push++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errs++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
    end
    repeat (2) @(negedge clk);
  endtask

  logic [W-1:0] bb_a[4];
  logic [W-1:0] bb_b[4];
  logic [W-1:0] bb_d[4];
  logic         bb_br[4];
  logic         bb_ov[4];

  initial begin
    bb_a = '{8'h0A, 8'h03, 8'h7F, 8'h40};
    bb_b = '{8'h03, 8'h0A, 8'hFF, 8'h40};
    bb_d = '{8'h07, 8'hF9, 8'h80, 8'h00};
    bb_br = '{1'b0, 1'b1, 1'b1, 1'b0};
    bb_ov = '{1'b0, 1'b0, 1'b1, 1'b0};

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
    chk("busy_run", {31'd0, busy}, 32'd1);
    wait_idle();
    issue(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1);
    wait_idle();
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("hold_diff", {24'd0, diff}, 32'h7F);

    // Abort mid-run: outputs clear at once and no done ever appears.
    issue(8'h55, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Second start while busy must be ignored.
    issue(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    issue(8'h10, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("busy_reject", {31'd0, busy}, 32'd1);
    wait_idle();

    // start held high: a new operation every W+2 cycles.
    @(negedge clk);
    start = 1'b1;
    a = bb_a[0];
    b = bb_b[0];
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      e.d = bb_d[i]; e.br = bb_br[i]; e.ov = bb_ov[i]; e.cyc = cyc + W;
      q.push_back(e);
      n_push++;
      if (i < 3) begin
        a = bb_a[i+1];
        b = bb_b[i+1];
        repeat (9) @(posedge clk);
      end else begin
        start = 1'b0;
      end
    end
    wait_idle();

    chk("done_count", n_done, n_push);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation counterpart of the full-adder datapath and serves as the area-minimal arithmetic unit for multi-cycle datapaths. It uses a start/done handshake and holds the result until the next accepted start.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits, must be 2 or greater.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request; sampled only in IDLE.
- `a`, input, WIDTH: minuend; captured on the accepted start edge.
- `b`, input, WIDTH: subtrahend; captured on the accepted start edge.
- `busy`, output, 1: high while in RUN or DONE.
- `done`, output, 1: one-cycle pulse; result valid.
- `diff`, output, WIDTH: `a - b` mod 2^WIDTH; held after done.
- `borrow_out`, output, 1: final borrow; 1 iff unsigned `a < b`.
- `ovf`, output, 1: signed overflow; present only with `SUB_OVERFLOW_EN`.

## Operation
- FSM states are IDLE, RUN and DONE. Encoding is free.
- Reset (async, `rst_n`=0):
  - Enters IDLE.
  - Clears the shift registers, the bit counter and the borrow flip-flop.
  - Drives `busy`=0, `done`=0, `diff`=0, `borrow_out`=0, `ovf`=0.
- IDLE with `start`=1:
  - Loads `a` and `b` into shift registers.
  - Sets borrow=0 and count=0, then goes to RUN.
  - `start`=0 keeps IDLE. Outputs hold their previous result.
- RUN, each cycle, with `ai` and `bi` as the current LSBs:
  - `d = ai ^ bi ^ br`.
  - `br' = (~ai & bi) | (~(ai ^ bi) & br)`.
  - `d` shifts into the MSB of the result register. Both operand registers shift right. count increments.
  - When count = WIDTH-1, the next edge goes to DONE with the full result and the final borrow registered.
- DONE:
  - `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
  - `start` in DONE is ignored.
- `start` in RUN or DONE has no effect; operands are not re-captured.
- `diff` and `borrow_out` update only on the transition into DONE. They never show partial results.
  - Hold the partial result internally. Copy it to `diff` on the RUN→DONE edge.
- Changes on `a`/`b` after capture have no effect.
- Reset mid-RUN aborts immediately. The next operation starts clean, with no stale borrow.
- Counter width is `$clog2(WIDTH)`. Count never wraps within an operation.

## Timing
- The start edge is edge 0.
- Edges 1..WIDTH are the RUN bit-cycles. The bit-cycle at edge k processes bit k-1.
- `done` is high during the cycle after edge WIDTH. It is observable WIDTH cycles after the accepted start edge.
- `busy` rises after edge 0 and falls after edge WIDTH+1.
- Minimum start-to-start spacing is WIDTH+2 cycles. `start` held high continuously restarts at each IDLE.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- `SUB_OVERFLOW_EN` defined:
  - Adds output `ovf`, registered with `diff` on entry to DONE.
  - `ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1])`, using the captured operand MSBs.
  - Requires retaining the two captured sign bits.
- `SUB_OVERFLOW_EN` undefined: the `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Basic subtraction: `a`=0x05, `b`=0x03, start pulse → `done` 8 cycles later, `diff`=0x02, `borrow_out`=0, `ovf`=0.
- Borrow: `a`=0x03, `b`=0x05 → `diff`=0xFE, `borrow_out`=1, `ovf`=0.
- Signed overflow: `a`=0x80, `b`=0x01 → `diff`=0x7F, `borrow_out`=0, `ovf`=1 (with macro). A build without the macro elaborates with no `ovf` port.
- Busy rejection: start with 0xFF−0xFF, then pulse start with 0x10, 0x01 three cycles later → exactly one `done`, `diff`=0x00, `borrow_out`=0.
- Mid-operation reset: assert `rst_n`=0 at RUN bit 4, same cycle → `busy`=0, `diff`=0, no `done`. Then 0x00−0x01 → `diff`=0xFF, `borrow_out`=1.
- Back-to-back: hold `start`=1 with alternating operands → `done` pulses every 10 cycles with the correct `diff` each time.
